// File: rtl/sub_serial_if.sv
// rtl/sub_serial_if.sv - request/result bundle for the nibble-serial subtractor
interface sub_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, d, bout, zero, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout, zero, ovf
    );
endinterface

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - WIDTH-bit subtractor built from one 4-bit slice reused per nibble
module sub_serial #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;

    // The single shared 4-bit slice: a + ~b + carry on the current nibble
    always_comb begin
        a_nib = a_q[{idx_q, 2'b00} +: 4];
        b_nib = b_q[{idx_q, 2'b00} +: 4];
        slice = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
    end

    // Next-state and datapath control; results are only published on the last nibble
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    d_d     = '0;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    bout_d  = 1'b0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                d_d[{idx_q, 2'b00} +: 4] = slice[3:0];
                carry_d = slice[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    // Carry out of a + ~b + 1 is the inverse of the unsigned borrow
                    bout_d  = ~slice[4];
                    zero_d  = (d_d == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b1;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - directed self-checking bench for sub_serial
module tb_sub_serial;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sub_serial_if #(.WIDTH(32)) bus ();

    sub_serial #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; cnt is the number of edges after the accept edge (8 expected)
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.done !== 1'b1 && cnt < 30);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eb, input logic ez, input logic eo);
        int cnt;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_flags_busy"}, 64'({bus.bout, bus.zero, bus.ovf, bus.done}), 64'd0);
        wait_done(cnt);
        chk({tag, "_latency"}, 64'(cnt), 64'd8);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_d"}, 64'(bus.d), 64'(ed));
        chk({tag, "_flags"}, 64'({bus.bout, bus.zero, bus.ovf}), 64'({eb, ez, eo}));
        tick();
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold"}, 64'({bus.d, bus.bout, bus.zero, bus.ovf}), 64'({ed, eb, ez, eo}));
    endtask

    initial begin
        int cnt;
        int pulses;
        int done_at;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("reset_state", 64'({bus.busy, bus.done, bus.bout, bus.zero, bus.ovf}), 64'd0);
        chk("reset_d", 64'(bus.d), 64'd0);

        // First start coincides with reset release
        rst = 1'b0;
        run_op("5m3", 32'd5, 32'd3, 32'h00000002, 1'b0, 1'b0, 1'b0);
        run_op("3m5", 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        run_op("min_m1", 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        run_op("max_mneg1", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1);
        run_op("equal", 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0);
        run_op("ones_m0", 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("carry_chain", 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);

        // Starts during a run are ignored
        bus.start = 1'b1;
        bus.a     = 32'h00000100;
        bus.b     = 32'h00000001;
        tick();
        pulses  = 0;
        done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.start = (i >= 1 && i <= 4);
            bus.a     = 32'd5;
            bus.b     = 32'd3;
            tick();
            if (bus.done === 1'b1) begin
                pulses++;
                done_at = i;
                chk("ignore_d", 64'(bus.d), 64'h000000FF);
            end
        end
        chk("ignore_pulses", 64'(pulses), 64'd1);
        chk("ignore_latency", 64'(done_at), 64'd8);

        // Start held through the done cycle is accepted back-to-back
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd4;
        tick();
        bus.a = 32'd20;
        bus.b = 32'd1;
        wait_done(cnt);
        chk("b2b_first_latency", 64'(cnt), 64'd8);
        chk("b2b_first_d", 64'(bus.d), 64'd6);
        tick();
        bus.start = 1'b0;
        chk("b2b_done_drop", 64'(bus.done), 64'd0);
        chk("b2b_busy_again", 64'(bus.busy), 64'd1);
        wait_done(cnt);
        chk("b2b_second_latency", 64'(cnt), 64'd8);
        chk("b2b_second_d", 64'(bus.d), 64'd19);

        // Reset in the middle of a run aborts without a done pulse
        tick();
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outputs", 64'({bus.busy, bus.done, bus.bout, bus.zero, bus.ovf}), 64'd0);
        chk("abort_d", 64'(bus.d), 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        run_op("after_abort", 32'd9, 32'd2, 32'd7, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
